// File: rtl/sa_column_feeder_pkg.sv
// Shared widths and FSM state encoding for the systolic-array column feeder.
package sa_column_feeder_pkg;

    // Activation / weight lane width (two's complement).
    localparam int unsigned P1_ACT    = 8;
    // Partial-sum width carried down the PE column.
    localparam int unsigned P1_PSUM   = 32;
    // Weight register width inside each PE; matches the activation lane.
    localparam int unsigned P1_WEIGHT = P1_ACT;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/sa_result_reg.sv
// Single-entry ready/valid capture register for the column-bottom partial sum.
module sa_result_reg #(
    parameter int unsigned PSUM = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            capture,
    input  logic [PSUM-1:0] cap_data,
    input  logic            res_ready,
    output logic            res_valid,
    output logic [PSUM-1:0] res_data,
    output logic            can_accept
);

    logic            valid_q, valid_d;
    logic [PSUM-1:0] data_q, data_d;

    // Next-state: a capture wins over a drain so back-to-back results never bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (capture) begin
            valid_d = 1'b1;
            data_d  = cap_data;
        end else if (res_ready) begin
            valid_d = 1'b0;
        end
    end

    // State register; data is held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign res_valid  = valid_q;
    assign res_data   = data_q;
    // A slot is free if empty or being drained this cycle.
    assign can_accept = !valid_q || res_ready;

endmodule

// File: rtl/sa_column_feeder.sv
// Sequencing front-end for one weight-stationary PE column: loads one weight
// per row, then streams activation vectors and captures the column sum.
module sa_column_feeder
    import sa_column_feeder_pkg::*;
#(
    parameter int unsigned ROWS = 4,
    parameter int unsigned ACT  = P1_ACT,
    parameter int unsigned PSUM = P1_PSUM
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [ACT-1:0]      w_data,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [ROWS*ACT-1:0] a_data,
    input  logic                a_last,
    output logic [ROWS*ACT-1:0] pe_in,
    output logic [ROWS-1:0]     pe_en_store,
    input  logic [PSUM-1:0]     col_psum,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [PSUM-1:0]     res_data,
    output logic                busy
);

    localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RowW-1:0] LastRow = RowW'(ROWS - 1);

    feeder_state_e   state_q, state_d;
    logic [RowW-1:0] row_q, row_d;
    logic            can_accept;
    logic            w_hs;
    logic            a_hs;

    // Handshakes are qualified by state; stray valids outside their phase are dropped.
    always_comb begin
        w_ready = (state_q == StLoad);
        a_ready = (state_q == StRun) && can_accept;
        w_hs    = w_ready && w_valid;
        a_hs    = a_ready && a_valid;
        busy    = (state_q != StIdle);
    end

    // Next-state and row counter; start is only honoured from idle.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    row_d   = '0;
                end
            end
            StLoad: begin
                if (w_hs) begin
                    if (row_q == LastRow) begin
                        state_d = StRun;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + RowW'(1);
                    end
                end
            end
            StRun: begin
                if (a_hs && a_last) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                row_d   = '0;
            end
        endcase
    end

    // FSM and row counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // Lane mux: zero lanes without a handshake so idle PEs pass psum_in through.
    always_comb begin
        pe_in       = '0;
        pe_en_store = '0;
        if (w_hs) begin
            pe_en_store[row_q]         = 1'b1;
            pe_in[row_q*ACT +: ACT]    = w_data;
        end else if (a_hs) begin
            pe_in = a_data;
        end
    end

    sa_result_reg #(
        .PSUM(PSUM)
    ) u_result_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture    (a_hs),
        .cap_data   (col_psum),
        .res_ready  (res_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .can_accept (can_accept)
    );

endmodule
